// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between the response sources, the UART transmitter and the
// arbiter that shares the transmitter between them.
interface uart_tx_arbiter_if #(
  parameter int unsigned NUM_REQ = 2
);
  logic [NUM_REQ-1:0]   req_vld;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_full;
  logic [NUM_REQ-1:0]   req_sent;
  logic                 trmt;
  logic [7:0]           resp;
  logic                 tx_done;
  logic                 tx_busy;
  logic                 timeout_err;
  logic                 clr_err;

  modport master (
    output req_vld, req_data, tx_done, clr_err,
    input  req_full, req_sent, trmt, resp, tx_busy, timeout_err
  );

  modport slave (
    input  req_vld, req_data, tx_done, clr_err,
    output req_full, req_sent, trmt, resp, tx_busy, timeout_err
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmit path between NUM_REQ one-byte
// holding buffers, with a watchdog that abandons a byte the UART never finishes.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned TIMEOUT = 32768
) (
  input  logic              clk,
  input  logic              rst_n,
  uart_tx_arbiter_if.slave  bus
);
  localparam int unsigned PW = $clog2(NUM_REQ);
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT} state_t;

  state_t             state, next_state;
  logic [7:0]         data_buf [NUM_REQ];
  logic [NUM_REQ-1:0] full_q;
  logic [NUM_REQ-1:0] sent_q;
  logic [7:0]         resp_q;
  logic [PW-1:0]      ptr;
  logic [PW-1:0]      cur;
  logic [PW-1:0]      sel;
  logic [PW-1:0]      ptr_next;
  logic [PW-1:0]      idx;
  logic               found;
  logic               grant;
  logic               trmt_c;
  logic               tx_done_q;
  logic               done_edge;
  logic               expire;
  logic               err_q;
  logic [TW-1:0]      timer;

  assign done_edge = bus.tx_done & ~tx_done_q;
  assign expire    = (timer == TW'(TIMEOUT - 1));

  // First occupied buffer at or above ptr, wrapping around.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = PW'((32'(ptr) + k) % NUM_REQ);
      if (!found && full_q[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
  end

  assign ptr_next = (sel == PW'(NUM_REQ - 1)) ? '0 : sel + PW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    grant      = 1'b0;
    trmt_c     = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          grant      = 1'b1;
          next_state = LAUNCH;
        end
      end
      LAUNCH: begin
        trmt_c     = 1'b1;
        next_state = WAIT;
      end
      WAIT: begin
        if (done_edge || expire) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) data_buf[i] <= '0;
      full_q    <= '0;
      sent_q    <= '0;
      resp_q    <= '0;
      ptr       <= '0;
      cur       <= '0;
      tx_done_q <= 1'b0;
      timer     <= '0;
      err_q     <= 1'b0;
    end else begin
      tx_done_q <= bus.tx_done;
      sent_q    <= '0;

      // A strobe on the buffer being granted is accepted: resp already holds
      // the old byte, so the buffer can take the new one on the same edge.
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (bus.req_vld[i] && (!full_q[i] || (grant && sel == PW'(i)))) begin
          data_buf[i] <= bus.req_data[8*i +: 8];
          full_q[i]   <= 1'b1;
        end else if (grant && sel == PW'(i)) begin
          full_q[i]   <= 1'b0;
        end
      end

      if (grant) begin
        resp_q <= data_buf[sel];
        cur    <= sel;
        ptr    <= ptr_next;
      end

      if (state == LAUNCH)               timer <= '0;
      else if (state == WAIT && !expire) timer <= timer + TW'(1);

      if (state == WAIT && done_edge) sent_q[cur] <= 1'b1;

      if (state == WAIT && expire && !done_edge) err_q <= 1'b1;
      else if (bus.clr_err)                      err_q <= 1'b0;
    end
  end

  assign bus.req_full    = full_q;
  assign bus.req_sent    = sent_q;
  assign bus.trmt        = trmt_c;
  assign bus.resp        = resp_q;
  assign bus.tx_busy     = (state != IDLE);
  assign bus.timeout_err = err_q;
endmodule
